// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered ALU between R0 and R1; response ALU_LAT+2 cycles after accept (error ops: 1 cycle).
// One op in flight: requests are refused while busy, and a response holds until its owner asserts rsp_ready.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             gnt0, gnt1;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             bad_op;
    logic             owner_rdy;

    // last_q=1 means R1 won the previous contested or uncontested grant
    assign gnt1   = (state_q == IDLE) && r1_valid && (!r0_valid || !last_q);
    assign gnt0   = (state_q == IDLE) && r0_valid && !gnt1;
    assign sel_op = gnt1 ? r1_op : r0_op;
    assign sel_a  = gnt1 ? r1_a  : r0_a;
    assign sel_b  = gnt1 ? r1_b  : r0_b;
    assign bad_op = (sel_op == 3'd0) ||
                    (((sel_op == 3'd4) || (sel_op == 3'd5)) && (sel_b == '0));
    assign owner_rdy = owner_q ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_op_d   = alu_op_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        rsp0_vld_d = rsp0_vld_q;
        rsp1_vld_d = rsp1_vld_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    if (bad_op) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b0;
                        rsp0_vld_d = gnt0;
                        rsp1_vld_d = gnt1;
                        state_d    = RESP;
                    end else begin
                        alu_op_d = sel_op;
                        in1_d    = sel_a;
                        in2_d    = sel_b;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_op_d = 3'd0;
                cnt_d    = LAT_W'(ALU_LAT);
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    rsp_data_d = alu_result;
                    rsp_zero_d = (alu_result == '0);
                    rsp_err_d  = 1'b0;
                    rsp0_vld_d = !owner_q;
                    rsp1_vld_d = owner_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (owner_rdy) begin
                    rsp0_vld_d = 1'b0;
                    rsp1_vld_d = 1'b0;
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            alu_op_q   <= 3'd0;
            in1_q      <= '0;
            in2_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_op_q   <= alu_op_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            op_count_q <= op_count_d;
        end
    end

    assign r0_ready     = gnt0;
    assign r1_ready     = gnt1;
    assign r0_rsp_valid = rsp0_vld_q;
    assign r1_rsp_valid = rsp1_vld_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_err      = rsp_err_q;
    assign alu_op       = alu_op_q;
    assign alu_in1      = in1_q;
    assign alu_in2      = in2_q;
    assign busy         = (state_q != IDLE);
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural one-cycle registered ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [2:0]  r0_op;
    logic [15:0] r0_a, r0_b;
    logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [2:0]  r1_op;
    logic [15:0] r1_a, r1_b;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_err;
    logic [2:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_result;
    logic        busy;
    logic [15:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;
    int grants   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .ALU_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
        .busy(busy), .op_count(op_count)
    );

    // External ALU: registered, output held while alu_op is 0
    always_ff @(posedge clk) begin
        if (rst) alu_result <= 16'h0;
        else begin
            case (alu_op)
                3'd1: alu_result <= alu_in1 + alu_in2;
                3'd2: alu_result <= alu_in1 ^ alu_in2;
                3'd3: alu_result <= alu_in1 * alu_in2;
                3'd4: alu_result <= (alu_in2 == 16'h0) ? 16'h0 : alu_in1 / alu_in2;
                3'd5: alu_result <= (alu_in2 == 16'h0) ? 16'h0 : alu_in1 % alu_in2;
                3'd6: alu_result <= alu_in1 << 1;
                3'd7: alu_result <= alu_in1 - alu_in2;
                default: alu_result <= alu_result;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit who, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_d, input bit exp_z,
                          input bit exp_e, input logic [15:0] exp_cnt);
        if (!who) begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
        else      begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
        #1;
        chk("grant", 32'({r0_ready, r1_ready}), who ? 32'h1 : 32'h2);
        tick;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        #1;
        chk("busy_after_accept", 32'(busy), 32'h1);
        if (!exp_e) begin
            chk("issue_op", 32'(alu_op), 32'(op));
            chk("issue_in1", 32'(alu_in1), 32'(a));
            chk("issue_in2", 32'(alu_in2), 32'(b));
            tick;
            chk("wait_op_zero", 32'(alu_op), 32'h0);
            chk("wait_no_rsp", 32'({r0_rsp_valid, r1_rsp_valid}), 32'h0);
            tick;
        end else begin
            chk("err_alu_idle", 32'(alu_op), 32'h0);
        end
        chk("rsp_valid", 32'({r0_rsp_valid, r1_rsp_valid}), who ? 32'h1 : 32'h2);
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_z));
        chk("rsp_err", 32'(rsp_err), 32'(exp_e));
        tick;
        chk("rsp_cleared", 32'({r0_rsp_valid, r1_rsp_valid}), 32'h0);
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r0_op = 3'd0; r0_a = 16'h0; r0_b = 16'h0; r0_rsp_ready = 1'b1;
        r1_valid = 1'b0; r1_op = 3'd0; r1_a = 16'h0; r1_b = 16'h0; r1_rsp_ready = 1'b1;
        tick; tick; tick;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_in1", 32'(alu_in1), 32'h0);
        chk("rst_in2", 32'(alu_in2), 32'h0);
        chk("rst_rsp", 32'({r0_rsp_valid, r1_rsp_valid, rsp_zero, rsp_err}), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_count", 32'(op_count), 32'h0);
        rst = 1'b0;
        tick;

        // Single ops: add, sub to zero, truncated mul
        run_op(1'b0, 3'd1, 16'h1234, 16'h0111, 16'h1345, 1'b0, 1'b0, 16'd1);
        run_op(1'b1, 3'd7, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0, 16'd2);
        run_op(1'b1, 3'd3, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 16'd3);
        // Rejected ops: divide by zero, opcode 0; then a legal div and mod
        run_op(1'b0, 3'd4, 16'd10,   16'd0,    16'h0000, 1'b0, 1'b1, 16'd4);
        run_op(1'b1, 3'd0, 16'd7,    16'd9,    16'h0000, 1'b0, 1'b1, 16'd5);
        run_op(1'b0, 3'd4, 16'd100,  16'd7,    16'h000E, 1'b0, 1'b0, 16'd6);
        run_op(1'b1, 3'd5, 16'd100,  16'd0,    16'h0000, 1'b0, 1'b1, 16'd7);
        run_op(1'b0, 3'd5, 16'd100,  16'd7,    16'h0002, 1'b0, 1'b0, 16'd8);

        // Continuous contention after reset: strict alternation starting at R0
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("rst2_count", 32'(op_count), 32'h0);
        r0_valid = 1'b1; r0_op = 3'd1; r0_a = 16'd1;     r0_b = 16'd1;
        r1_valid = 1'b1; r1_op = 3'd2; r1_a = 16'hF0F0;  r1_b = 16'h0FF0;
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("never_both_ready", 32'(r0_ready & r1_ready), 32'h0);
            if (r0_ready || r1_ready) begin
                chk("rr_order", 32'(r1_ready), 32'(grants % 2));
                grants++;
            end
            if (r0_rsp_valid) chk("rr_r0_data", 32'(rsp_data), 32'h0002);
            if (r1_rsp_valid) chk("rr_r1_data", 32'(rsp_data), 32'hFF00);
            @(posedge clk);
            #1;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("rr_grant_count", 32'(grants), 32'd10);
        chk("rr_op_count", 32'(op_count), 32'd10);
        chk("rr_idle", 32'(busy), 32'h0);

        // R0 response stalled for 4 cycles while R1 waits
        r0_rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = 3'd1; r0_a = 16'h00FF; r0_b = 16'h0001;
        #1;
        chk("stall_grant", 32'({r0_ready, r1_ready}), 32'h2);
        tick;
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_op = 3'd1; r1_a = 16'd2; r1_b = 16'd3;
        #1;
        chk("stall_r1_blocked_issue", 32'(r1_ready), 32'h0);
        tick; tick;
        for (int i = 0; i < 4; i++) begin
            chk("stall_vld", 32'(r0_rsp_valid), 32'h1);
            chk("stall_data", 32'(rsp_data), 32'h0100);
            chk("stall_flags", 32'({rsp_zero, rsp_err, r1_rsp_valid}), 32'h0);
            chk("stall_r1_ready", 32'(r1_ready), 32'h0);
            tick;
        end
        r0_rsp_ready = 1'b1;
        #1;
        chk("stall_hs_vld", 32'(r0_rsp_valid), 32'h1);
        chk("stall_hs_r1_ready", 32'(r1_ready), 32'h0);
        tick;
        chk("stall_done", 32'(r0_rsp_valid), 32'h0);
        chk("stall_r1_granted", 32'(r1_ready), 32'h1);
        chk("stall_count", 32'(op_count), 32'd11);
        tick;
        r1_valid = 1'b0;
        tick; tick;
        chk("r1_after_stall_vld", 32'(r1_rsp_valid), 32'h1);
        chk("r1_after_stall_data", 32'(rsp_data), 32'h0005);
        tick;
        chk("r1_after_stall_count", 32'(op_count), 32'd12);

        // Reset during WAIT drops the op
        r0_valid = 1'b1; r0_op = 3'd1; r0_a = 16'd4; r0_b = 16'd4;
        tick;
        r0_valid = 1'b0;
        tick;
        chk("pre_rst_wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_wait_busy", 32'(busy), 32'h0);
        chk("rst_wait_alu_op", 32'(alu_op), 32'h0);
        chk("rst_wait_count", 32'(op_count), 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("rst_wait_no_rsp", 32'({r0_rsp_valid, r1_rsp_valid}), 32'h0);
            tick;
        end
        chk("rst_wait_count_end", 32'(op_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Controller that shares the single registered 16-bit ALU between two requesters (R0 = core sequencer, R1 = auxiliary unit) using round-robin arbitration. It accepts one operation at a time over a valid/ready request channel and drives alu_op, in1 and in2 for exactly one cycle. It waits the ALU's fixed latency, captures the result and returns it over a per-requester valid/ready response channel. It computes its own zero flag, screens illegal operations, and holds alu_op at 0 while idle so the ALU retains its output.

Parameters:
WIDTH, 16, operand/result width.
ALU_LAT, 1, cycles from op issue edge to valid alu_out (>=1).
CNT_W, 16, width of completed-operation counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
r0_valid  in  1  R0 request valid
r0_ready  out  1  R0 request accepted this cycle
r0_op  in  3  R0 opcode (ALU encoding: 1 add, 2 xor, 3 mul, 4 div, 5 mod, 6 x2, 7 sub)
r0_a  in  WIDTH  R0 operand A (to in1)
r0_b  in  WIDTH  R0 operand B (to in2)
r0_rsp_valid  out  1  response for R0 valid
r0_rsp_ready  in  1  R0 accepts response
r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_rsp_valid, r1_rsp_ready: same as the R0 signals, for R1
rsp_data  out  WIDTH  result, shared, valid with either rsp_valid
rsp_zero  out  1  rsp_data == 0
rsp_err  out  1  operation rejected
alu_op  out  3  to ALU alu_op
alu_in1  out  WIDTH  to ALU in1
alu_in2  out  WIDTH  to ALU in2
alu_result  in  WIDTH  from ALU alu_out
busy  out  1  state != IDLE
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset values: state IDLE, rr pointer favours R0, alu_op=0, alu_in1=alu_in2=0, rsp_data=0, rsp_zero=0, rsp_err=0, all rsp_valid=0, op_count=0, busy=0. All outputs are registered except rX_ready.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration: rX_ready is combinational, high only in IDLE for the granted requester.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not granted last. The pointer updates on grant only.
- Accept edge: latch op, a, b and owner.
  - Op 0, or op 4/5 with b==0: go directly to RESP with rsp_err=1, rsp_data=0, rsp_zero=0. The ALU is never driven.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): alu_op=latched op, alu_in1=a, alu_in2=b. Load wait counter = ALU_LAT. Go to WAIT.
- WAIT: alu_op=0, operands held. Counter decrements each cycle. On the edge where the counter reaches 0:
  - rsp_data <= alu_result
  - rsp_zero <= (alu_result==0)
  - rsp_err <= 0
  - go to RESP.
- The ALU's own z flag lags alu_out by a cycle and is not used.
- Result arithmetic is the ALU's: truncated to WIDTH, unsigned. Mul keeps the low 16 bits.
- RESP: owner's rsp_valid=1 with data, zero and err stable. Hold until the owner's rsp_ready=1. On that edge: rsp_valid=0, op_count+1 (wraps at 2^CNT_W; errors count too), go to IDLE.
- Latency (accept cycle A):
  - Normal op: first rsp_valid cycle is A+2+ALU_LAT, so A+3 for ALU_LAT=1.
  - Error op: A+1.
  - Earliest next accept is the cycle after the response handshake.
- A new request arriving while busy is not accepted; its valid/fields must be held by the requester.
- Non-owner rsp_ready is ignored.
- Reset in any state: return to IDLE next edge, drop the pending op and response, alu_op=0 immediately.

Test Plan:
- R0 add a=0x1234 b=0x0111, ALU_LAT=1 -> r0_ready in cycle A; alu_op=1 only in A+1; r0_rsp_valid at A+3, rsp_data=0x1345, rsp_zero=0, op_count=1.
- R1 sub 5-5, then mul 300*300 -> first rsp_data=0, rsp_zero=1; second rsp_data=0x5F90 (90000 mod 65536 = 24464).
- R0 div a=10 b=0, and R1 op=0 -> rsp_err=1 one cycle after accept, alu_op never nonzero, op_count increments for both.
- r0_valid and r1_valid held high continuously, each rsp_ready tied 1 -> grants alternate R0,R1,R0,R1, starting with R0 after reset; no cycle ever has both ready.
- R0 response with r0_rsp_ready low for 4 cycles, r1_valid high meanwhile -> rsp fields stable, r1_ready stays 0 until the cycle after the R0 handshake.
- rst asserted during WAIT -> next cycle IDLE, busy=0, no rsp_valid ever for that op, op_count=0.
